cache_fill_responder: RTL and testbench

- Memory-side responder for the stage-4 data cache.
- Accepts cache requests over a valid/ready handshake.
  - Line refills: returns LINE_WORDS words as a burst after a fixed access latency.
  - Word writes: write-through stores, acknowledged one cycle after acceptance.
- Holds the backing word array (MEM_SIZE words) that the cache miss path refills from.

---
 rtl/cache_fill_pkg.sv | 26 ++
 rtl/cache_fill_mem_array.sv | 42 ++++
 rtl/cache_fill_responder.sv | 160 ++++++++++++++++
 tb/tb_cache_fill_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_fill_pkg : shared types and width helpers for the cache fill responder
// Revision: 1.0
// ----------------------------------------------------------------------------
package cache_fill_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Clamped to 1 so single-word lines still get a legal counter width.
  function automatic int offset_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

  function automatic int addr_w(input int mem_size);
    return (mem_size > 1) ? $clog2(mem_size) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_fill_mem_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_fill_mem_array : single-port word array, sync write, registered read
// Revision: 1.0
// ----------------------------------------------------------------------------
module cache_fill_mem_array
  import cache_fill_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MEM_SIZE = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_we,
  input  logic                        i_re,
  input  logic [addr_w(MEM_SIZE)-1:0] i_addr,
  input  logic [WIDTH-1:0]            i_wdata,
  output logic [WIDTH-1:0]            o_rdata
);

  logic [WIDTH-1:0] r_mem [0:MEM_SIZE-1];
  logic [WIDTH-1:0] r_rdata;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cache_fill_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_fill_responder : backing-store responder for data cache line refills
// and write-through word stores. Optional CACHE_FILL_RESPONDER_CWF_EN enables
// critical-word-first wrapping bursts.
// Revision: 1.0
// ----------------------------------------------------------------------------
module cache_fill_responder
  import cache_fill_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MEM_SIZE     = 32,
  parameter int LINE_WORDS   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [addr_w(MEM_SIZE)-1:0] req_addr,
  input  logic [WIDTH-1:0]            req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [WIDTH-1:0]            resp_data,
  output logic                        resp_last,
  output logic                        wr_ack,
  output logic                        busy
);

  localparam int                  c_addr_w    = addr_w(MEM_SIZE);
  localparam int                  c_off_w     = offset_w(LINE_WORDS);
  localparam logic [c_addr_w-1:0] c_off_mask  = c_addr_w'(LINE_WORDS - 1);
  localparam logic [c_off_w-1:0]  c_last_beat = c_off_w'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]    c_lat       = LAT_W'(READ_LATENCY);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_addr_w-1:0] r_base;
  logic [c_addr_w-1:0] r_start;
  logic [c_off_w-1:0]  r_beat;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic                r_wr_ack;

  logic                w_accept;
  logic                w_wr_en;
  logic                w_rd_en;
  logic                w_beat_fire;
  logic [c_addr_w-1:0] w_req_base;
  logic [c_addr_w-1:0] w_req_start;
  logic [c_addr_w-1:0] w_beat_off;
  logic [c_addr_w-1:0] w_rd_addr;
  logic [c_addr_w-1:0] w_mem_addr;
  logic [WIDTH-1:0]    w_rd_data;

  assign req_ready   = (r_state == ST_IDLE) && !rst;
  assign w_accept    = req_valid && req_ready;
  assign w_wr_en     = w_accept && req_write;
  assign w_beat_fire = (r_state == ST_BURST) && resp_ready;
  assign w_req_base  = req_addr & ~c_off_mask;

`ifdef CACHE_FILL_RESPONDER_CWF_EN
  assign w_req_start = req_addr & c_off_mask;
`else
  assign w_req_start = '0;
`endif

  // Offset of the word that follows the one currently on the bus, wrapped in-line.
  assign w_beat_off = (r_start + c_addr_w'(r_beat) + c_addr_w'(1)) & c_off_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_base | r_start;
    case (r_state)
      ST_IDLE: begin
        w_rd_addr = w_req_base | w_req_start;
        if (w_accept && !req_write) begin
          if (c_lat == '0) begin
            w_state_nxt = ST_BURST;
            w_rd_en     = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_lat_cnt == LAT_W'(1)) begin
          w_state_nxt = ST_BURST;
          w_rd_en     = 1'b1;
        end
      end
      ST_BURST: begin
        w_rd_addr = r_base | w_beat_off;
        if (resp_ready) begin
          w_rd_en = 1'b1;
          if (r_beat == c_last_beat) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base    <= '0;
      r_start   <= '0;
      r_beat    <= '0;
      r_lat_cnt <= '0;
      r_wr_ack  <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_en;
      if (w_accept && !req_write) begin
        r_base    <= w_req_base;
        r_start   <= w_req_start;
        r_beat    <= '0;
        r_lat_cnt <= c_lat;
      end else if (r_state == ST_WAIT) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end
      if (w_beat_fire) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Writes only occur in IDLE, never alongside a read fetch.
  assign w_mem_addr = w_wr_en ? req_addr : w_rd_addr;

  cache_fill_mem_array #(
    .WIDTH    (WIDTH),
    .MEM_SIZE (MEM_SIZE)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_en),
    .i_re    (w_rd_en),
    .i_addr  (w_mem_addr),
    .i_wdata (req_wdata),
    .o_rdata (w_rd_data)
  );

  assign resp_valid = (r_state == ST_BURST);
  assign resp_last  = resp_valid && (r_beat == c_last_beat);
  assign resp_data  = w_rd_data;
  assign wr_ack     = r_wr_ack;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cache_fill_responder : table-driven, directed and randomized bench
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_cache_fill_responder;

`ifdef CACHE_FILL_RESPONDER_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_last, wr_ack, busy;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata, resp_data;

  logic        l0_req_valid, l0_req_ready, l0_req_write, l0_resp_valid, l0_resp_ready;
  logic        l0_resp_last, l0_wr_ack, l0_busy;
  logic [4:0]  l0_req_addr;
  logic [31:0] l0_req_wdata, l0_resp_data;

  cache_fill_responder #(.WIDTH(32), .MEM_SIZE(32), .LINE_WORDS(4), .READ_LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_last(resp_last), .wr_ack(wr_ack), .busy(busy)
  );

  cache_fill_responder #(.WIDTH(32), .MEM_SIZE(32), .LINE_WORDS(4), .READ_LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst), .req_valid(l0_req_valid), .req_ready(l0_req_ready),
    .req_write(l0_req_write), .req_addr(l0_req_addr), .req_wdata(l0_req_wdata),
    .resp_valid(l0_resp_valid), .resp_ready(l0_resp_ready), .resp_data(l0_resp_data),
    .resp_last(l0_resp_last), .wr_ack(l0_wr_ack), .busy(l0_busy)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wvec_t;

  typedef struct packed {
    logic [4:0]       addr;
    logic [3:0][31:0] exp;
  } rvec_t;

  wvec_t wvec[12];
  rvec_t rvec[3];

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [32];
  logic [31:0] got_data [8];
  logic        got_last [8];
  int n_beats, first_cyc, busy_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: line base is the aligned address, start offset wraps within the line.
  function automatic logic [31:0] exp_word(input logic [4:0] a, input int k);
    int base;
    int start;
    base  = int'(a) - (int'(a) % 4);
    start = CWF ? (int'(a) % 4) : 0;
    return ref_mem[base + ((start + k) % 4)];
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    check1("wr_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    ref_mem[a] = d;
    check1("wr_ack_pulse", wr_ack, 1'b1);
    check1("wr_no_resp_valid", resp_valid, 1'b0);
  endtask

  task automatic do_read(input logic [4:0] a, input int stall_beat, input int stall_n,
                         input bit rnd);
    int          stalled;
    logic [31:0] held;
    bit          done;
    n_beats = 0; first_cyc = -1; busy_cyc = 0; stalled = 0; held = '0; done = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    check1("rd_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (!busy) begin
        done = 1'b1;
      end else begin
        busy_cyc++;
        check1("busy_no_wr_ack", wr_ack, 1'b0);
        if (resp_valid) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (rnd) begin
            resp_ready = 1'($urandom_range(0, 1));
          end else if (n_beats == stall_beat && stalled < stall_n) begin
            resp_ready = 1'b0;
            if (stalled == 0) held = resp_data;
            else check("stall_hold", resp_data, held);
            stalled++;
          end else begin
            if (stalled > 0 && n_beats == stall_beat) check("stall_release", resp_data, held);
            resp_ready = 1'b1;
          end
          if (resp_ready && n_beats < 8) begin
            got_data[n_beats] = resp_data;
            got_last[n_beats] = resp_last;
            n_beats++;
          end
        end else begin
          resp_ready = 1'b0;
        end
        // Requests offered while busy must be ignored.
        if (rnd) begin
          req_valid = 1'($urandom_range(0, 1)); req_write = 1'b1;
          req_addr = 5'($urandom); req_wdata = $urandom;
        end
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
    if (!done) check1("rd_timeout", busy, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] ra;
    for (int i = 0; i < 4; i++) begin
      wvec[i]     = '{addr: 5'(i),      data: 32'hA0 + 32'(i)};
      wvec[4 + i] = '{addr: 5'(8 + i),  data: 32'h10 + 32'(i)};
      wvec[8 + i] = '{addr: 5'(28 + i), data: 32'h1C + 32'(i)};
    end
    rvec[0].addr = 5'd9;  rvec[1].addr = 5'd31; rvec[2].addr = 5'd2;
    if (CWF) begin
      rvec[0].exp = {32'h10, 32'h13, 32'h12, 32'h11};
      rvec[1].exp = {32'h1E, 32'h1D, 32'h1C, 32'h1F};
      rvec[2].exp = {32'hA1, 32'hA0, 32'hA3, 32'hA2};
    end else begin
      rvec[0].exp = {32'h13, 32'h12, 32'h11, 32'h10};
      rvec[1].exp = {32'h1F, 32'h1E, 32'h1D, 32'h1C};
      rvec[2].exp = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    l0_req_valid = 1'b0; l0_req_write = 1'b0; l0_req_addr = '0; l0_req_wdata = '0;
    l0_resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_resp_valid", resp_valid, 1'b0);
    check1("rst_resp_last", resp_last, 1'b0);
    check1("rst_wr_ack", wr_ack, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_data", resp_data, 32'h0);
    rst = 1'b0;
    #1;
    check1("post_rst_req_ready", req_ready, 1'b1);

    // Back-to-back writes.
    do_write(5'd5, 32'hA5A5_0005);
    do_write(5'd6, 32'h0000_0006);
    check1("b2b_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    check1("wr_ack_drop", wr_ack, 1'b0);

    foreach (wvec[i]) do_write(wvec[i].addr, wvec[i].data);

    foreach (rvec[i]) begin
      do_read(rvec[i].addr, -1, 0, 1'b0);
      check("tbl_latency", first_cyc, 32'd2);
      check("tbl_beats", n_beats, 32'd4);
      check("tbl_busy_cycles", busy_cyc, 32'd6);
      check1("tbl_ready_after", req_ready, 1'b1);
      for (int k = 0; k < 4; k++) begin
        check("tbl_data", got_data[k], rvec[i].exp[k]);
        check1("tbl_last", got_last[k], k == 3);
      end
    end

    // Backpressure on beat 1 for three cycles.
    do_read(5'd9, 1, 3, 1'b0);
    check("stall_beats", n_beats, 32'd4);
    for (int k = 0; k < 4; k++) check("stall_data", got_data[k], rvec[0].exp[k]);

    // Reset during beat 2.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd8; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    begin
      int n;
      n = 0;
      for (int c = 0; c < 20; c++) begin
        if (resp_valid) begin
          if (n == 2) break;
          n++;
        end
        @(posedge clk); #1;
      end
    end
    check("mid_beat2_data", resp_data, 32'h12);
    resp_ready = 1'b0;
    rst = 1'b1;
    #1;
    check1("mid_rst_resp_valid", resp_valid, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_resp_last", resp_last, 1'b0);
    check1("mid_rst_req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check1("mid_rst_release_ready", req_ready, 1'b1);
    do_read(5'd2, -1, 0, 1'b0);
    check("mid_rst_reread_beats", n_beats, 32'd4);
    for (int k = 0; k < 4; k++) check("mid_rst_reread_data", got_data[k], rvec[2].exp[k]);

    // Zero-latency instance.
    l0_resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      l0_req_valid = 1'b1; l0_req_write = 1'b1; l0_req_addr = 5'(16 + i);
      l0_req_wdata = 32'hF00 + 32'(i);
      @(posedge clk); #1;
      check1("l0_wr_ack", l0_wr_ack, 1'b1);
    end
    l0_req_valid = 1'b1; l0_req_write = 1'b0; l0_req_addr = 5'd17;
    check1("l0_req_ready", l0_req_ready, 1'b1);
    @(posedge clk); #1;
    l0_req_valid = 1'b0;
    check1("l0_first_beat_valid", l0_resp_valid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("l0_data", l0_resp_data, 32'hF00 + 32'(((CWF ? 1 : 0) + k) % 4));
      check1("l0_last", l0_resp_last, k == 3);
      @(posedge clk); #1;
    end
    check1("l0_idle_after", l0_busy, 1'b0);

    // Randomized traffic against the reference array.
    for (int i = 0; i < 32; i++) do_write(5'(i), $urandom);
    for (int op = 0; op < 60; op++) begin
      ra = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) begin
        do_write(ra, $urandom);
      end else begin
        do_read(ra, -1, 0, 1'b1);
        check("rnd_beats", n_beats, 32'd4);
        for (int k = 0; k < 4; k++) begin
          check("rnd_data", got_data[k], exp_word(ra, k));
          check1("rnd_last", got_last[k], k == 3);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
